jk_bank_ctrl: RTL and testbench



---
 rtl/jk_bank_ctrl_if.sv | 32 +++
 rtl/jk_bank_ctrl.sv | 165 ++++++++++++++++
 tb/tb_jk_bank_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/jk_bank_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : jk_bank_ctrl_if
// Brief    : Command handshake and status bundle for jk_bank_ctrl.
//            master = host/test controller side, slave = sequencer side.
// Revision : 1.0  initial release
// ============================================================================
interface jk_bank_ctrl_if #(
  parameter int WIDTH = 4
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_mask;
  logic [3:0]       cmd_count;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_op, cmd_mask, cmd_count,
    input  cmd_ready, q, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_mask, cmd_count,
    output cmd_ready, q, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/jk_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : jk_bank_ctrl
// Brief    : Command sequencer driving a bank of WIDTH JK cells. Each accepted
//            command (op, mask, count) is applied to the masked cells on
//            count+1 consecutive edges; done pulses once per command.
//            Optional macro JK_BANK_SKID_EN adds a one-entry command buffer
//            so commands can run back-to-back with no idle edge.
// Revision : 1.0  initial release
// ============================================================================
module jk_bank_ctrl #(
  parameter int WIDTH = 4
) (
  input  wire            clk,
  input  wire            reset,
  jk_bank_ctrl_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_APPLY = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [1:0]       r_op,   w_op_nx;
  logic [WIDTH-1:0] r_mask, w_mask_nx;
  logic [3:0]       r_remaining, w_remaining_nx;
  logic [WIDTH-1:0] r_q,    w_q_nx;
  logic             r_busy, w_busy_nx;
  logic             r_done, w_done_nx;

  logic             w_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic [WIDTH-1:0] w_q_applied;

`ifdef JK_BANK_SKID_EN
  logic             r_buf_valid, w_buf_valid_nx;
  logic [1:0]       r_buf_op,    w_buf_op_nx;
  logic [WIDTH-1:0] r_buf_mask,  w_buf_mask_nx;
  logic [3:0]       r_buf_count, w_buf_count_nx;

  // Ready depends only on buffer occupancy, never on cmd_valid.
  assign w_ready = !r_buf_valid;
`else
  assign w_ready = (r_state == ST_IDLE);
`endif

  assign w_accept = bus.cmd_valid && w_ready;

  // Unmasked cells see J=K=0 and therefore hold.
  assign w_j         = r_mask & {WIDTH{r_op[1]}};
  assign w_k         = r_mask & {WIDTH{r_op[0]}};
  assign w_q_applied = (w_j & ~r_q) | (~w_k & r_q);

  // Next-state and datapath decisions for the sequencer.
  always_comb begin
    w_state_nx     = r_state;
    w_op_nx        = r_op;
    w_mask_nx      = r_mask;
    w_remaining_nx = r_remaining;
    w_q_nx         = r_q;
    w_done_nx      = 1'b0;
`ifdef JK_BANK_SKID_EN
    w_buf_valid_nx = r_buf_valid;
    w_buf_op_nx    = r_buf_op;
    w_buf_mask_nx  = r_buf_mask;
    w_buf_count_nx = r_buf_count;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_op_nx        = bus.cmd_op;
          w_mask_nx      = bus.cmd_mask;
          w_remaining_nx = bus.cmd_count;
          w_state_nx     = ST_APPLY;
        end
      end
      ST_APPLY: begin
        w_q_nx = w_q_applied;
        if (r_remaining != 4'd0) begin
          w_remaining_nx = r_remaining - 4'd1;
`ifdef JK_BANK_SKID_EN
          if (w_accept) begin
            w_buf_valid_nx = 1'b1;
            w_buf_op_nx    = bus.cmd_op;
            w_buf_mask_nx  = bus.cmd_mask;
            w_buf_count_nx = bus.cmd_count;
          end
`endif
        end else begin
          w_done_nx = 1'b1;
`ifdef JK_BANK_SKID_EN
          if (r_buf_valid) begin
            w_op_nx        = r_buf_op;
            w_mask_nx      = r_buf_mask;
            w_remaining_nx = r_buf_count;
            w_buf_valid_nx = 1'b0;
          end else if (w_accept) begin
            // Arrives on the completion edge: chain straight in, no gap.
            w_op_nx        = bus.cmd_op;
            w_mask_nx      = bus.cmd_mask;
            w_remaining_nx = bus.cmd_count;
          end else begin
            w_state_nx = ST_IDLE;
          end
`else
          w_state_nx = ST_IDLE;
`endif
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
    w_busy_nx = (w_state_nx == ST_APPLY);
  end

  // State register with synchronous reset that discards any pending work.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Registered datapath and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op        <= 2'b00;
      r_mask      <= '0;
      r_remaining <= 4'd0;
      r_q         <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef JK_BANK_SKID_EN
      r_buf_valid <= 1'b0;
      r_buf_op    <= 2'b00;
      r_buf_mask  <= '0;
      r_buf_count <= 4'd0;
`endif
    end else begin
      r_op        <= w_op_nx;
      r_mask      <= w_mask_nx;
      r_remaining <= w_remaining_nx;
      r_q         <= w_q_nx;
      r_busy      <= w_busy_nx;
      r_done      <= w_done_nx;
`ifdef JK_BANK_SKID_EN
      r_buf_valid <= w_buf_valid_nx;
      r_buf_op    <= w_buf_op_nx;
      r_buf_mask  <= w_buf_mask_nx;
      r_buf_count <= w_buf_count_nx;
`endif
    end
  end

  assign bus.cmd_ready = w_ready;
  assign bus.q         = r_q;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_jk_bank_ctrl
// Brief    : Directed self-checking bench for jk_bank_ctrl (WIDTH=4).
//            Each observation is packed as {q, busy, done, cmd_ready}.
//            Builds with or without JK_BANK_SKID_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_jk_bank_ctrl;

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_RESET  = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

`ifdef JK_BANK_SKID_EN
  // With the buffer empty the block stays ready while executing.
  localparam logic RA = 1'b1;
`else
  localparam logic RA = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  jk_bank_ctrl_if #(.WIDTH(4)) bus ();

  jk_bank_ctrl #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [6:0] snap();
    return {bus.q, bus.busy, bus.done, bus.cmd_ready};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op,
                       input logic [3:0] mask, input logic [3:0] cnt);
    bus.cmd_valid = v;
    bus.cmd_op    = op;
    bus.cmd_mask  = mask;
    bus.cmd_count = cnt;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, OP_SET, 4'b1111, 4'd0);   // must be ignored under reset
    tick();
    tick();
    vectors++;
    if (snap() !== 7'b0000_001) begin
      miscompares++;
      $display("FAIL reset_hold: got %b want %b", snap(), 7'b0000_001);
    end
    drive(1'b0, OP_HOLD, 4'b0000, 4'd0);
    reset = 1'b0;
    tick();
    vectors++;
    if (snap() !== 7'b0000_001) begin
      miscompares++;
      $display("FAIL reset_release: got %b want %b", snap(), 7'b0000_001);
    end
  endtask

  task automatic test_set();
    logic [6:0] exp_t [3];
    exp_t = '{ {4'b0000, 1'b1, 1'b0, RA},
               {4'b0101, 1'b0, 1'b1, 1'b1},
               {4'b0101, 1'b0, 1'b0, 1'b1} };
    drive(1'b1, OP_SET, 4'b0101, 4'd0);
    tick();
    drive(1'b0, OP_HOLD, 4'b0000, 4'd0);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (snap() !== exp_t[i]) begin
        miscompares++;
        $display("FAIL set step %0d: got %b want %b", i, snap(), exp_t[i]);
      end
      if (i < 2) tick();
    end
  endtask

  task automatic test_toggle();
    logic [6:0] exp_t [5];
    exp_t = '{ {4'b0101, 1'b1, 1'b0, RA},
               {4'b1010, 1'b1, 1'b0, RA},
               {4'b0101, 1'b1, 1'b0, RA},
               {4'b1010, 1'b0, 1'b1, 1'b1},
               {4'b1010, 1'b0, 1'b0, 1'b1} };
    drive(1'b1, OP_TOGGLE, 4'b1111, 4'd2);
    tick();
    drive(1'b0, OP_HOLD, 4'b0000, 4'd0);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (snap() !== exp_t[i]) begin
        miscompares++;
        $display("FAIL toggle step %0d: got %b want %b", i, snap(), exp_t[i]);
      end
      if (i < 4) tick();
    end
  endtask

  task automatic test_reset_then_hold();
    logic [6:0] exp_r [2];
    logic [6:0] exp_h [6];
    exp_r = '{ {4'b1010, 1'b1, 1'b0, RA},
               {4'b1000, 1'b0, 1'b1, 1'b1} };
    exp_h = '{ {4'b1000, 1'b1, 1'b0, RA},
               {4'b1000, 1'b1, 1'b0, RA},
               {4'b1000, 1'b1, 1'b0, RA},
               {4'b1000, 1'b1, 1'b0, RA},
               {4'b1000, 1'b0, 1'b1, 1'b1},
               {4'b1000, 1'b0, 1'b0, 1'b1} };
    drive(1'b1, OP_RESET, 4'b0010, 4'd0);
    tick();
    drive(1'b0, OP_HOLD, 4'b0000, 4'd0);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (snap() !== exp_r[i]) begin
        miscompares++;
        $display("FAIL reset_cmd step %0d: got %b want %b", i, snap(), exp_r[i]);
      end
      if (i < 1) tick();
    end
    // Issued in the done cycle, when the block is idle again.
    drive(1'b1, OP_HOLD, 4'b1111, 4'd3);
    tick();
    drive(1'b0, OP_HOLD, 4'b0000, 4'd0);
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (snap() !== exp_h[i]) begin
        miscompares++;
        $display("FAIL hold step %0d: got %b want %b", i, snap(), exp_h[i]);
      end
      if (i < 5) tick();
    end
  endtask

  task automatic test_reset_mid_command();
    logic [6:0] exp_t [5];
    exp_t = '{ {4'b1000, 1'b1, 1'b0, RA},
               {4'b1001, 1'b1, 1'b0, RA},
               {4'b1000, 1'b1, 1'b0, RA},
               {4'b1001, 1'b1, 1'b0, RA},
               {4'b1000, 1'b1, 1'b0, RA} };
    drive(1'b1, OP_TOGGLE, 4'b0001, 4'd15);
    tick();
    drive(1'b0, OP_HOLD, 4'b0000, 4'd0);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (snap() !== exp_t[i]) begin
        miscompares++;
        $display("FAIL midreset apply %0d: got %b want %b", i, snap(), exp_t[i]);
      end
      if (i < 4) tick();
    end
    // Fifth APPLY cycle: reset, with a competing command that must lose.
    reset = 1'b1;
    drive(1'b1, OP_SET, 4'b1111, 4'd0);
    tick();
    vectors++;
    if (snap() !== 7'b0000_001) begin
      miscompares++;
      $display("FAIL midreset flush: got %b want %b", snap(), 7'b0000_001);
    end
    reset = 1'b0;
    drive(1'b0, OP_HOLD, 4'b0000, 4'd0);
    tick();
    vectors++;
    if (snap() !== 7'b0000_001) begin
      miscompares++;
      $display("FAIL midreset no_done: got %b want %b", snap(), 7'b0000_001);
    end
    drive(1'b1, OP_SET, 4'b0110, 4'd0);
    tick();
    drive(1'b0, OP_HOLD, 4'b0000, 4'd0);
    vectors++;
    if (snap() !== {4'b0000, 1'b1, 1'b0, RA}) begin
      miscompares++;
      $display("FAIL midreset new_busy: got %b want %b", snap(), {4'b0000, 1'b1, 1'b0, RA});
    end
    tick();
    vectors++;
    if (snap() !== 7'b0110_011) begin
      miscompares++;
      $display("FAIL midreset new_done: got %b want %b", snap(), 7'b0110_011);
    end
  endtask

  task automatic test_back_to_back();
`ifdef JK_BANK_SKID_EN
    localparam int N = 5;
    localparam int DROP = 1;
    logic [6:0] exp_t [N];
    exp_t = '{ 7'b0000_101,
               7'b0011_100,
               7'b0000_111,
               7'b1100_011,
               7'b1100_001 };
`else
    localparam int N = 6;
    localparam int DROP = 3;
    logic [6:0] exp_t [N];
    exp_t = '{ 7'b0000_100,
               7'b0011_100,
               7'b0000_011,
               7'b0000_100,
               7'b1100_011,
               7'b1100_001 };
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b1, OP_TOGGLE, 4'b0011, 4'd1);
    tick();
    drive(1'b1, OP_SET, 4'b1100, 4'd0);
    for (int i = 0; i < N; i++) begin
      vectors++;
      if (snap() !== exp_t[i]) begin
        miscompares++;
        $display("FAIL b2b step %0d: got %b want %b", i, snap(), exp_t[i]);
      end
      if (i == DROP) drive(1'b0, OP_HOLD, 4'b0000, 4'd0);
      if (i < N - 1) tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, OP_HOLD, 4'b0000, 4'd0);
    test_reset();
    test_set();
    test_toggle();
    test_reset_then_hold();
    test_reset_mid_command();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
